// File: rtl/load_store_unit.sv
// RV64 load/store unit: sequences byte/half/word/double accesses onto a doubleword memory port,
// doing read-modify-write for sub-doubleword stores. Define LSU_MISALIGN_TRAP_EN to trap misaligned
// accesses; otherwise they are aligned down and complete normally.

module load_store_unit #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        resp_valid,
    output logic [63:0] rdata,
    output logic        error,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StWr,
        StResp
    } state_e;

    localparam logic [2:0] LatLast = 3'(MEM_LAT - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    // Captured request
    logic [2:0]  lane_q;
    logic [2:0]  funct3_q;
    logic        store_q;
    logic [63:0] wdata_q;

    // Registered outputs
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        error_q, error_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [63:0] rdata_q, rdata_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;

    // Request decode, evaluated on the live inputs while idle
    logic [2:0]  req_off_mask;
    logic        req_illegal;
    logic        req_trap;
    logic        req_err;
    logic        req_full;
    logic [2:0]  req_lane;
    logic        accept;

    always_comb begin
        case (funct3[1:0])
            2'b00:   req_off_mask = 3'b000;
            2'b01:   req_off_mask = 3'b001;
            2'b10:   req_off_mask = 3'b011;
            default: req_off_mask = 3'b111;
        endcase
    end

    assign req_illegal = (funct3 == 3'b111) || (is_store && (funct3[2:1] == 2'b11));

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_trap = |(addr[2:0] & req_off_mask);
`else
    assign req_trap = 1'b0;
`endif

    assign req_err  = req_illegal || req_trap;
    assign req_full = (funct3[1:0] == 2'b11);
    // Low offset bits below the access width are dropped (align down)
    assign req_lane = addr[2:0] & ~req_off_mask;
    assign accept   = req_valid && (state_q == StIdle);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q   <= 3'b000;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
            wdata_q  <= 64'd0;
        end else if (accept) begin
            lane_q   <= req_lane;
            funct3_q <= funct3;
            store_q  <= is_store;
            wdata_q  <= wdata;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (is_store && req_full) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                state_d = StWait;
                cnt_d   = LatLast;
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = store_q ? StWr : StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane extraction and merge on the doubleword returned by memory
    logic [63:0] rd_shift;
    logic [63:0] load_ext;
    logic [63:0] byte_mask;
    logic [63:0] lane_mask;
    logic [63:0] merged;

    assign rd_shift = mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{56{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'b011:  load_ext = rd_shift;
            3'b100:  load_ext = {56'd0, rd_shift[7:0]};
            3'b101:  load_ext = {48'd0, rd_shift[15:0]};
            3'b110:  load_ext = {32'd0, rd_shift[31:0]};
            default: load_ext = 64'd0;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   byte_mask = 64'h0000_0000_0000_00ff;
            2'b01:   byte_mask = 64'h0000_0000_0000_ffff;
            2'b10:   byte_mask = 64'h0000_0000_ffff_ffff;
            default: byte_mask = 64'hffff_ffff_ffff_ffff;
        endcase
    end

    assign lane_mask = byte_mask << {lane_q, 3'b000};
    assign merged    = (mem_rdata & ~lane_mask) | ((wdata_q << {lane_q, 3'b000}) & lane_mask);

    // Output logic: next values of the registered outputs
    always_comb begin
        req_ready_d  = (state_d == StIdle);
        mem_read_d   = (state_d == StRd);
        mem_write_d  = (state_d == StWr);
        resp_valid_d = (state_d == StResp);
        // Only the error path jumps straight from idle to the response
        error_d      = (state_q == StIdle) && (state_d == StResp);
        rdata_d      = rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if (accept) begin
            mem_addr_d = {3'b000, addr[63:3]};
        end
        if ((state_q == StIdle) && (state_d == StWr)) begin
            mem_wdata_d = wdata;
        end
        if ((state_q == StWait) && (state_d == StWr)) begin
            mem_wdata_d = merged;
        end
        if (state_d == StResp) begin
            rdata_d = (state_q == StWait) ? load_ext : 64'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            error_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            rdata_q      <= 64'd0;
            mem_addr_q   <= 64'd0;
            mem_wdata_q  <= 64'd0;
        end else begin
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            error_q      <= error_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            rdata_q      <= rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign error      = error_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign rdata      = rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (MEM_LAT 1 and 3) against a byte-level reference
// memory, with a response scoreboard. Honours LSU_MISALIGN_TRAP_EN like the design.

module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        is_store   [2];
    logic [2:0]  funct3     [2];
    logic [63:0] addr       [2];
    logic [63:0] wdata      [2];
    logic        resp_valid [2];
    logic [63:0] rdata      [2];
    logic        error      [2];
    logic        mem_read   [2];
    logic        mem_write  [2];
    logic [63:0] mem_addr   [2];
    logic [63:0] mem_wdata  [2];
    logic [63:0] mem_rdata  [2];

    load_store_unit #(.MEM_LAT(1)) dut0 (
        .clk(clk), .reset(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .is_store(is_store[0]), .funct3(funct3[0]), .addr(addr[0]), .wdata(wdata[0]),
        .resp_valid(resp_valid[0]), .rdata(rdata[0]), .error(error[0]),
        .MemRead(mem_read[0]), .MemWrite(mem_write[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    load_store_unit #(.MEM_LAT(3)) dut1 (
        .clk(clk), .reset(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .is_store(is_store[1]), .funct3(funct3[1]), .addr(addr[1]), .wdata(wdata[1]),
        .resp_valid(resp_valid[1]), .rdata(rdata[1]), .error(error[1]),
        .MemRead(mem_read[1]), .MemWrite(mem_write[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    // Memory: 16 doublewords per instance; read data walks a delay line, garbage otherwise
    logic [63:0] mem  [2][16];
    logic [63:0] pipe [2][4];
    logic        bd_we = 1'b0;
    int          bd_d;
    int          bd_idx;
    logic [63:0] bd_data;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_write[d]) mem[d][mem_addr[d][3:0]] <= mem_wdata[d];
            pipe[d][0] <= mem_read[d] ? mem[d][mem_addr[d][3:0]] : {$urandom, $urandom};
            for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
        end
        if (bd_we) mem[bd_d][bd_idx] <= bd_data;
    end

    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          d;
        logic [63:0] rdata;
        logic        err;
        int          acc;
        int          lat;
        int          nrd;
        int          nwr;
        logic [63:0] maddr;
        logic [63:0] wword;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] ref_mem [2][16];
    int          total = 0;
    int          bad = 0;

    function automatic void check64(string name, int d, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h required %h", name, d, act, exp);
        end
    endfunction

    // Monitor: strobes, response contents, latency, rdata hold
    int          nrd [2];
    int          nwr [2];
    logic [63:0] held [2];
    exp_t        mon_e;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                nrd[d] = 0;
                nwr[d] = 0;
                held[d] = 64'd0;
            end else begin
                if (mem_read[d] || mem_write[d])
                    check64("strobe exclusive", d, 64'(mem_read[d] & mem_write[d]), 64'd0);
                if (mem_read[d]) begin
                    nrd[d]++;
                    if (sb.size() > 0 && sb[0].d == d)
                        check64("read mem_addr", d, mem_addr[d], sb[0].maddr);
                end
                if (mem_write[d]) begin
                    nwr[d]++;
                    if (sb.size() > 0 && sb[0].d == d) begin
                        check64("write mem_addr", d, mem_addr[d], sb[0].maddr);
                        check64("write mem_wdata", d, mem_wdata[d], sb[0].wword);
                    end
                end
                if (resp_valid[d]) begin
                    if (sb.size() == 0 || sb[0].d != d) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected response dut%0d: got resp_valid=1 required 0", d);
                    end else begin
                        mon_e = sb.pop_front();
                        check64("rdata", d, rdata[d], mon_e.rdata);
                        check64("error", d, 64'(error[d]), 64'(mon_e.err));
                        check64("latency", d, 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                        check64("MemRead count", d, 64'(nrd[d]), 64'(mon_e.nrd));
                        check64("MemWrite count", d, 64'(nwr[d]), 64'(mon_e.nwr));
                    end
                    held[d] = rdata[d];
                    nrd[d] = 0;
                    nwr[d] = 0;
                end else begin
                    check64("rdata hold", d, rdata[d], held[d]);
                end
            end
        end
    end

    // Reference model: byte view of the memory, computed from the access rules
    task automatic model(input int d, input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input bit upd, output exp_t e);
        int          size;
        int          off;
        int          boff;
        int          idx;
        int          mlat;
        logic        illegal;
        logic        trap;
        logic [63:0] al;
        logic [63:0] w;
        logic [63:0] v;
        logic [63:0] m;
        mlat = (d == 0) ? 1 : 3;
        size = 1 << f3[1:0];
        off  = int'(a % 64'(size));
        e.d = d; e.rdata = 64'd0; e.err = 1'b0; e.acc = 0; e.lat = 1;
        e.nrd = 0; e.nwr = 0; e.maddr = a >> 3; e.wword = 64'd0;
        illegal = (f3 == 3'b111) || (st && f3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (off != 0);
`else
        trap = 1'b0;
`endif
        if (illegal || trap) begin
            e.err = 1'b1;
            return;
        end
        al   = a - 64'(off);
        idx  = int'(al >> 3);
        boff = int'(al % 64'd8);
        w    = ref_mem[d][idx];
        if (!st) begin
            v = 64'd0;
            for (int i = 0; i < size; i++) v |= 64'(w[(boff + i) * 8 +: 8]) << (8 * i);
            if (size < 8) begin
                m = (64'd1 << (8 * size)) - 64'd1;
                if (!f3[2] && v[8 * size - 1]) v |= ~m;
            end
            e.rdata = v;
            e.lat = 2 + mlat;
            e.nrd = 1;
        end else begin
            for (int i = 0; i < size; i++) w[(boff + i) * 8 +: 8] = wd[8 * i +: 8];
            if (upd) ref_mem[d][idx] = w;
            e.wword = w;
            e.lat = (size == 8) ? 2 : 3 + mlat;
            e.nrd = (size == 8) ? 0 : 1;
            e.nwr = 1;
        end
    endtask

    task automatic bd_write(input int d, input int idx, input logic [63:0] v);
        @(negedge clk);
        bd_d = d; bd_idx = idx; bd_data = v; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[d][idx] = v;
    endtask

    task automatic issue(input int d, input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input bit keep, output int acc);
        exp_t e;
        int   n;
        model(d, st, f3, a, wd, keep, e);
        @(negedge clk);
        is_store[d] = st; funct3[d] = f3; addr[d] = a; wdata[d] = wd; req_valid[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            total++;
            bad++;
            $display("FAIL accept timeout dut%0d: got req_ready=0 required 1", d);
            req_valid[d] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        e.acc = cyc;
        if (keep) sb.push_back(e);
        @(negedge clk);
        req_valid[d] = 1'b0;
        addr[d] = {$urandom, $urandom};
        wdata[d] = {$urandom, $urandom};
        funct3[d] = 3'($urandom_range(0, 7));
        is_store[d] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL response timeout: got %0d pending required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        int          a0;
        int          a1;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] a;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; is_store[d] = 1'b0; funct3[d] = 3'b000;
            addr[d] = 64'd0; wdata[d] = 64'd0;
        end
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) bd_write(d, i, {$urandom, $urandom});

        for (int d = 0; d < 2; d++) begin
            check64("reset MemRead", d, 64'(mem_read[d]), 64'd0);
            check64("reset MemWrite", d, 64'(mem_write[d]), 64'd0);
            check64("reset resp_valid", d, 64'(resp_valid[d]), 64'd0);
            check64("reset error", d, 64'(error[d]), 64'd0);
            check64("reset rdata", d, rdata[d], 64'd0);
            check64("reset mem_addr", d, mem_addr[d], 64'd0);
            check64("reset mem_wdata", d, mem_wdata[d], 64'd0);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check64("req_ready after reset", d, 64'(req_ready[d]), 64'd1);

        // LD, LB/LBU sign handling, SH read-modify-write
        bd_write(0, 3, 64'h8000_0000_0000_0001);
        issue(0, 1'b0, 3'b011, 64'h18, 64'd0, 1'b1, a0);
        wait_idle();
        bd_write(0, 3, 64'hff00_0000_0000_0000);
        issue(0, 1'b0, 3'b000, 64'h1f, 64'd0, 1'b1, a0);
        issue(0, 1'b0, 3'b100, 64'h1f, 64'd0, 1'b1, a0);
        wait_idle();
        bd_write(0, 2, 64'h1111_1111_1111_1111);
        issue(0, 1'b1, 3'b001, 64'h12, 64'h0000_0000_0000_beef, 1'b1, a0);
        wait_idle();
        check64("SH memory word", 0, mem[0][2], 64'h1111_1111_beef_1111);

        // Misaligned LW, illegal encodings
        bd_write(0, 4, 64'h0123_4567_89ab_cdef);
        issue(0, 1'b0, 3'b010, 64'h22, 64'd0, 1'b1, a0);
        issue(0, 1'b0, 3'b111, 64'h08, 64'd0, 1'b1, a0);
        issue(0, 1'b1, 3'b110, 64'h08, 64'h55, 1'b1, a0);
        wait_idle();

        // SD then LD at MEM_LAT=3, back-to-back
        issue(1, 1'b1, 3'b011, 64'h40, 64'hdead_beef_0bad_f00d, 1'b1, a0);
        issue(1, 1'b0, 3'b011, 64'h40, 64'd0, 1'b1, a1);
        check64("back-to-back accept gap", 1, 64'(a1 - a0), 64'd3);
        wait_idle();

        // Reset during the WAIT of an SB: aborted, nothing written, no response
        issue(0, 1'b1, 3'b000, 64'h05, 64'h0000_0000_0000_00a5, 1'b0, a0);
        check64("abort MemRead in RD", 0, 64'(mem_read[0]), 64'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check64("abort MemRead", 0, 64'(mem_read[0]), 64'd0);
        check64("abort MemWrite", 0, 64'(mem_write[0]), 64'd0);
        check64("abort resp_valid", 0, 64'(resp_valid[0]), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check64("req_ready after abort", 0, 64'(req_ready[0]), 64'd1);
        repeat (8) @(negedge clk);
        check64("abort memory word", 0, mem[0][0], ref_mem[0][0]);

        // Randomized traffic on both latencies
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 80; n++) begin
                st = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                a  = 64'($urandom_range(0, 127));
                if ($urandom_range(0, 1) == 1) a = a & ~64'((1 << f3[1:0]) - 1);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                issue(d, st, f3, a, {$urandom, $urandom}, 1'b1, a0);
            end
            wait_idle();
        end

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) check64("final memory", d, mem[d][i], ref_mem[d][i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
